// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone B4 arbiter sharing one slave-side bus
// between NUM_M masters. The grant is decided when a master raises CYC and
// is held until that master drops CYC. Masters that do not own the bus see
// a silent bus: no ACK/ERR/RTY.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN
//   When defined, a watchdog counts stalled strobe cycles. When the count
//   reaches TIMEOUT, the owner is sent a one-cycle ERR (TERM). The bus then
//   stays idle (DRAIN) until the owner drops CYC.
//   When undefined, a hung slave holds the grant indefinitely.
//
// Parameters
//   NUM_M    number of masters (2..8)
//   TIMEOUT  watchdog limit in stalled cycles (1..65535); watchdog build only
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   M_CYC/M_STB/M_WE   [NUM_M]   per-master cycle, strobe, write enable
//   M_ADR/M_DAT_O   [32*NUM_M]   per-master address / write data (slice 32i)
//   M_CTI            [3*NUM_M]   per-master cycle type identifier
//   M_ACK/M_ERR/M_RTY  [NUM_M]   per-master terminations (owner only)
//   M_DAT_I               [32]   slave read data broadcast to all masters
//   S_CYC/S_STB/S_WE             slave-side cycle, strobe, write enable
//   S_ADR/S_DAT_O         [32]   slave-side address / write data
//   S_CTI                  [3]   slave-side cycle type identifier
//   S_ACK/S_ERR/S_RTY            slave terminations
//   S_DAT_I               [32]   slave read data
//   GNT                [NUM_M]   registered one-hot grant, zero when idle
module wb_arbiter #(
  parameter int NUM_M   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_M-1:0]     M_CYC,
  input  logic [NUM_M-1:0]     M_STB,
  input  logic [NUM_M-1:0]     M_WE,
  input  logic [32*NUM_M-1:0]  M_ADR,
  input  logic [32*NUM_M-1:0]  M_DAT_O,
  input  logic [3*NUM_M-1:0]   M_CTI,
  output logic [NUM_M-1:0]     M_ACK,
  output logic [NUM_M-1:0]     M_ERR,
  output logic [NUM_M-1:0]     M_RTY,
  output logic [31:0]          M_DAT_I,
  output logic                 S_CYC,
  output logic                 S_STB,
  output logic                 S_WE,
  output logic [31:0]          S_ADR,
  output logic [31:0]          S_DAT_O,
  output logic [2:0]           S_CTI,
  input  logic                 S_ACK,
  input  logic                 S_ERR,
  input  logic                 S_RTY,
  input  logic [31:0]          S_DAT_I,
  output logic [NUM_M-1:0]     GNT
);

  localparam int IW = $clog2(NUM_M);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY, TERM, DRAIN} state_t;
`else
  typedef enum logic [0:0] {IDLE, BUSY} state_t;
`endif

  state_t           state_reg, state_next;
  logic [IW-1:0]    owner_reg, owner_next;
  logic [IW-1:0]    last_reg, last_next;
  logic [NUM_M-1:0] gnt_reg, gnt_next;
`ifdef WB_ARB_TIMEOUT_EN
  logic [CW-1:0]    cnt_reg, cnt_next;
`endif

  // Per-master buses unpacked into arrays so the owner mux is a plain index.
  logic [31:0] adr_arr [NUM_M];
  logic [31:0] dat_arr [NUM_M];
  logic [2:0]  cti_arr [NUM_M];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_unpack
      assign adr_arr[gi] = M_ADR[32*gi +: 32];
      assign dat_arr[gi] = M_DAT_O[32*gi +: 32];
      assign cti_arr[gi] = M_CTI[3*gi +: 3];
    end
  endgenerate

  logic busy_w;
  logic term_w;
  logic own_cyc;
  logic own_stb;
  logic any_term;

  assign busy_w   = (state_reg == BUSY);
`ifdef WB_ARB_TIMEOUT_EN
  assign term_w   = (state_reg == TERM);
`else
  assign term_w   = 1'b0;
`endif
  assign own_cyc  = M_CYC[owner_reg];
  assign own_stb  = M_STB[owner_reg] & M_CYC[owner_reg];
  assign any_term = S_ACK | S_ERR | S_RTY;

  // Round-robin pick: scan from the farthest candidate (last+NUM_M) down to
  // the nearest (last+1). The nearest requester is written last and wins.
  logic          win_valid;
  logic [IW-1:0] win_idx;

  always_comb begin
    int cand;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = NUM_M; k >= 1; k--) begin
      cand = (int'(last_reg) + k) % NUM_M;
      if (M_CYC[cand]) begin
        win_valid = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  // Slave-side forwarding. This path is combinational so that a slave ACK
  // reaches the owner on the same edge.
  always_comb begin
    S_CYC   = 1'b0;
    S_STB   = 1'b0;
    S_WE    = 1'b0;
    S_ADR   = '0;
    S_DAT_O = '0;
    S_CTI   = '0;
    if (busy_w) begin
      S_CYC   = own_cyc;
      S_STB   = own_stb;
      S_WE    = M_WE[owner_reg];
      S_ADR   = adr_arr[owner_reg];
      S_DAT_O = dat_arr[owner_reg];
      S_CTI   = cti_arr[owner_reg];
    end
  end

  assign M_DAT_I = S_DAT_I;

  // Terminations reach only the owner. In the TERM state, the watchdog ERR
  // is injected here.
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_term
      logic sel;
      assign sel       = (owner_reg == IW'(gi));
      assign M_ACK[gi] = busy_w & sel & S_ACK;
      assign M_RTY[gi] = busy_w & sel & S_RTY;
      assign M_ERR[gi] = (busy_w & sel & S_ERR) | (term_w & sel);
    end
  endgenerate

  assign GNT = gnt_reg;

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    gnt_next   = gnt_reg;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (win_valid) begin
          state_next = BUSY;
          owner_next = win_idx;
          gnt_next   = {{(NUM_M-1){1'b0}}, 1'b1} << win_idx;
`ifdef WB_ARB_TIMEOUT_EN
          cnt_next   = '0;
`endif
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_next = IDLE;
          last_next  = owner_reg;
          gnt_next   = '0;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (own_stb) begin
          if (any_term) begin
            cnt_next = '0;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            // This stalled cycle brings the count to TIMEOUT.
            state_next = TERM;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      TERM: begin
        state_next = DRAIN;
      end
      DRAIN: begin
        // Keep the grant until the aborted master abandons its cycle.
        if (!own_cyc) begin
          state_next = IDLE;
          last_next  = owner_reg;
          gnt_next   = '0;
        end
      end
`endif
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // The asynchronous reset drops the grant immediately. S_CYC/S_STB fall in
  // the same cycle, and the interrupted master sees no termination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      last_reg  <= IW'(NUM_M - 1);
      gnt_reg   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      gnt_reg   <= gnt_next;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

  // any_term only feeds the watchdog.
`ifndef WB_ARB_TIMEOUT_EN
  logic unused_ok;
  assign unused_ok = any_term;
`endif

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Round-robin Wishbone B4 arbiter that shares one slave-side bus between `NUM_M` masters (test masters, CPU fetch/load ports) on the SoC interconnect. Grant is decided per bus cycle (`CYC`) and held until the owning master drops `CYC`. Non-owners see a silent bus. An optional watchdog terminates hung cycles with `ERR`.

## Interface
- `NUM_M`, default 2: number of masters, 2–8.
- `TIMEOUT`, default 255: watchdog limit in cycles, 1–65535. Used only with `WB_ARB_TIMEOUT_EN`.
- `clk` in 1: the single clock for the block.
- `rst` in 1: asynchronous, active-high reset.
- `M_CYC`, `M_STB`, `M_WE` in `NUM_M` each: per-master cycle, strobe and write enable. Bit i belongs to master i.
- `M_ADR`, `M_DAT_O` in `32*NUM_M` each: per-master address and write data. Slice `[32i+31:32i]` belongs to master i.
- `M_CTI` in `3*NUM_M`: per-master cycle type identifier.
- `M_ACK`, `M_ERR`, `M_RTY` out `NUM_M` each: per-master termination signals.
- `M_DAT_I` out 32: read data, `S_DAT_I` broadcast to all masters.
- `S_CYC`, `S_STB`, `S_WE` out 1 each: slave-side cycle, strobe and write enable.
- `S_ADR`, `S_DAT_O` out 32 each: slave-side address and write data.
- `S_CTI` out 3: slave-side cycle type identifier.
- `S_ACK`, `S_ERR`, `S_RTY` in 1 each: slave terminations.
- `S_DAT_I` in 32: slave read data.
- `GNT` out `NUM_M`: registered one-hot grant; all zero when idle.

## Operation
- States:
  - `IDLE`: no grant.
  - `BUSY`: one master owns the bus.
  - `TERM` and `DRAIN`: watchdog only.
- IDLE → BUSY when any `M_CYC` bit is high. Winner is the first requester in order `last+1, last+2, …` (mod `NUM_M`), where `last` is the index of the previous owner. `GNT` and the owner index are registered on that edge.
- BUSY forwarding, combinational, muxed by the owner index:
  - `S_CYC = M_CYC[o]` and `S_STB = M_STB[o] & M_CYC[o]`.
  - `S_WE`, `S_ADR`, `S_DAT_O` and `S_CTI` come from master `o`.
  - `M_ACK[o]`, `M_ERR[o]` and `M_RTY[o]` follow the slave terminations. All other master bits are 0.
- BUSY → IDLE on the edge where `M_CYC[o]` is sampled low; `last <= o`, `GNT <= 0`.
- Multiple `STB` phases (back-to-back or burst `CTI`) inside one `CYC` keep the grant, with no re-arbitration.
- Outside BUSY: `S_CYC`, `S_STB`, `S_WE` = 0; `S_ADR`, `S_DAT_O`, `S_CTI` = 0; all `M_ACK`, `M_ERR`, `M_RTY` = 0.
- A master raising `CYC` while another owns the bus waits; it receives no terminations.
- Reset values:
  - State `IDLE`, `GNT` = 0, and `last = NUM_M-1`, so master 0 has first priority.
  - Watchdog counter 0; all outputs 0.
- Reset asserted mid-cycle: the grant clears asynchronously, so `S_CYC` and `S_STB` fall in the same cycle. The interrupted master gets no termination.

## Timing
- Grant latency:
  - `M_CYC` first sampled high at edge k → `GNT` valid and `S_CYC` high during cycle k..k+1.
  - Earliest slave `ACK` is therefore at edge k+1.
- Zero-latency pass-through while BUSY: slave `ACK` at edge n is seen by the owner at the same edge n.
- Release to next grant: owner `CYC` low at edge j → IDLE; the next owner is granted at edge j+1. This gives exactly one idle bus cycle between owners.
- Simultaneous requests at the same edge are resolved purely by round-robin order from `last`.
- Width rules: the owner index is `$clog2(NUM_M)` bits and wraps from `NUM_M-1` to 0.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - Counter: a `$clog2(TIMEOUT+1)`-bit counter increments every BUSY cycle where `S_STB=1` and no `S_ACK`/`S_ERR`/`S_RTY` arrives. It clears on any termination and on entry to BUSY.
  - Expiry: when the count reaches `TIMEOUT`, the state goes to TERM.
  - TERM lasts one cycle: `M_ERR[o]=1`, `S_CYC=S_STB=0`. Then go to DRAIN.
  - DRAIN: bus idle; wait for `M_CYC[o]` low, then go to IDLE with `last <= o`.
- Not defined: no counter and no TERM/DRAIN states; a hung slave holds the grant indefinitely.

## Test plan
- **Single write:** master 0 writes `ADR=0x10`, `DAT=0x10`, slave ACKs 1 cycle after `S_STB` → `GNT=01`, `S_ADR=0x10`, `M_ACK[0]` for 1 cycle, `GNT=00` one edge after `M_CYC[0]` falls.
- **Simultaneous requests:** masters 0 and 1 raise `CYC` on the same edge after reset → master 0 served first. Master 1 is granted exactly 1 cycle after master 0 drops `CYC`, and `M_ACK[1]` stays 0 until then.
- **Fairness:** both masters re-request continuously for 6 cycles → grants alternate 0,1,0,1,0,1.
- **Held grant:** master 1 issues 4 `STB` phases inside one `CYC` while master 0 requests → `GNT` stays 10 for all 4 ACKs.
- **Reset mid-cycle:** `rst` asserted while `S_STB=1` → `S_CYC=0`, `GNT=0` in the same cycle. After release, master 0 gets priority.
- **Watchdog:** with `WB_ARB_TIMEOUT_EN`, `TIMEOUT=8`, and a slave that never ACKs → `M_ERR[o]` pulses 1 cycle after 8 stalled `STB` cycles, with `S_CYC=0`. The other master is granted after the owner drops `CYC`.
